// File: rtl/bool_sweep_checker.sv
// rtl/bool_sweep_checker.sv - exhaustive 3-input sweep driver and checker for parallel logic implementations
// Optional: BOOL_SWEEP_HALT_ON_ERR_EN stops the sweep at the first mismatching vector.
module bool_sweep_checker #(
  parameter logic [7:0] TRUTH = 8'hD5,
  parameter int         N_DUT = 3,
  parameter int         ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [2:0]       abc,
  input  logic [N_DUT-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_DUT-1:0] err_mask,
  output logic [2:0]       first_err_vec,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t           state, state_nxt;
  logic [N_DUT-1:0] mism;
  logic             truth_bit;
  logic             halt_now;

  // Case-inequality so an X/Z on y is reported as a mismatch.
  always_comb begin
    truth_bit = TRUTH[abc];
    mism      = '0;
    for (int i = 0; i < N_DUT; i++) begin
      mism[i] = (y[i] !== truth_bit);
    end
  end

`ifdef BOOL_SWEEP_HALT_ON_ERR_EN
  assign halt_now = |mism;
`else
  assign halt_now = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE;
      DRIVE:      state_nxt = CHECK;
      CHECK:      state_nxt = (abc == 3'd7 || halt_now) ? DONE : DRIVE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      abc             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      err_mask        <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            abc             <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            err_mask        <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
          end
        end
        CHECK: begin
          if (|mism) begin
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            err_mask <= err_mask | mism;
            if (!first_err_valid) begin
              first_err_vec   <= abc;
              first_err_valid <= 1'b1;
            end
          end
          if (state_nxt == DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= ~|(err_mask | mism);
          end else begin
            abc <= abc + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bool_sweep_checker.sv
// tb/tb_bool_sweep_checker.sv - scoreboard bench for bool_sweep_checker with injected implementation faults
module tb_bool_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] y;
  logic [2:0] abc, abc2;
  logic       busy, done, pass, busy2, done2, pass2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [2:0] err_mask, err_mask2, fev, fev2;
  logic       fevv, fevv2;

  int fault = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic done_q = 1'b0;

  typedef struct {
    bit         exp_pass;
    int         exp_cnt;
    int         exp_cnt2;
    logic [2:0] exp_mask;
    logic [2:0] exp_fev;
    bit         exp_fevv;
    int         exp_cyc;
  } exp_t;
  exp_t sb[$];

  bool_sweep_checker #(.TRUTH(8'hD5), .N_DUT(3), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abc(abc), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .err_mask(err_mask), .first_err_vec(fev), .first_err_valid(fevv)
  );

  bool_sweep_checker #(.TRUTH(8'hD5), .N_DUT(3), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abc(abc2), .y(y),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .err_mask(err_mask2), .first_err_vec(fev2), .first_err_valid(fevv2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Three implementations of Y = A&B | ~C with selectable faults.
  always_comb begin
    logic g;
    g = (abc[2] & abc[1]) | ~abc[0];
    y = {g, g, g};
    if (fault == 1 && abc == 3'd5) y[1] = ~g;
    if (fault == 2) y[0] = 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    done_q <= done;
    if (rst_n && done && !done_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pass", int'(pass), int'(e.exp_pass));
        chk("err_cnt", int'(err_cnt), e.exp_cnt);
        chk("err_cnt_sat", int'(err_cnt2), e.exp_cnt2);
        chk("err_mask", int'(err_mask), int'(e.exp_mask));
        chk("first_err_valid", int'(fevv), int'(e.exp_fevv));
        chk("first_err_vec", int'(fev), int'(e.exp_fev));
        chk("done_cycle", cyc, e.exp_cyc);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic run_sweep(input int mode, input bit p, input int c, input int c2,
                           input logic [2:0] m, input logic [2:0] fv, input bit fvv,
                           input int pulse_at);
    exp_t e;
    fault = mode;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    e = '{p, c, c2, m, fv, fvv, cyc + 16};
    sb.push_back(e);
    chk("start_busy", int'(busy), 1);
    chk("start_done", int'(done), 0);
    chk("start_clr_cnt", int'(err_cnt), 0);
    chk("start_clr_mask", int'(err_mask), 0);
    chk("start_clr_fevv", int'(fevv), 0);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      start = (j == pulse_at);
      chk("abc_step", int'(abc), j / 2);
    end
    start = 1'b0;
    for (int t = 0; t < 10 && sb.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_abc", int'(abc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_cnt", int'(err_cnt), 0);
    chk("rst_mask", int'(err_mask), 0);
    chk("rst_fevv", int'(fevv), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_sweep(0, 1'b1, 0, 0, 3'b000, 3'd0, 1'b0, -1);
    run_sweep(1, 1'b0, 1, 1, 3'b010, 3'd5, 1'b1, -1);
    run_sweep(2, 1'b0, 5, 3, 3'b001, 3'd0, 1'b1, -1);
    run_sweep(0, 1'b1, 0, 0, 3'b000, 3'd0, 1'b0, 3);
    chk("done_hold", int'(done), 1);
    chk("abc_hold", int'(abc), 7);

    // start held high: one-cycle done, then immediate restart
    fault = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    begin
      exp_t e;
      e = '{1'b1, 0, 0, 3'b000, 3'd0, 1'b0, cyc + 16};
      sb.push_back(e);
    end
    repeat (16) @(negedge clk);
    #1;
    chk("held_popped", sb.size(), 0);
    @(negedge clk);
    chk("held_done_1cyc", int'(done), 0);
    chk("held_restart_busy", int'(busy), 1);
    chk("held_restart_abc", int'(abc), 0);
    fault = 2;
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_cnt", int'(err_cnt), 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_abc", int'(abc), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_cnt", int'(err_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_abc", int'(abc), 0);
    chk("idle_done", int'(done), 0);
    sb.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
